// File: rtl/sipo_pack.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_pack
//  Brief    : Serial-to-parallel packer of complex samples into PE_NUM-lane
//             frames, with flush of partial frames and a double-buffered output.
//  Revision : 1.0
// ============================================================================
module sipo_pack #(
   parameter int PE_NUM     = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             s_in_v,
   input  logic [2*DATA_WIDTH-1:0]          s_in,
   output logic                             s_in_rdy,
   input  logic                             flush,
   output logic                             p_out_v,
   output logic [PE_NUM*2*DATA_WIDTH-1:0]   p_out,
   input  logic                             p_out_rdy,
   output logic                             p_out_partial,
   output logic [$clog2(PE_NUM+1)-1:0]      fill_cnt
);

   localparam int SW = 2 * DATA_WIDTH;
   localparam int CW = $clog2(PE_NUM + 1);
   localparam logic [CW-1:0] C_LAST_CNT = CW'(PE_NUM - 1);
   localparam logic [CW-1:0] C_FULL_CNT = CW'(PE_NUM);

   typedef enum logic [0:0] {
      S_FILL = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t                      state_q;
   logic [PE_NUM-1:0][SW-1:0]   bank_q;
   logic                        bank_partial_q;
   logic [CW-1:0]               fill_cnt_q;
   logic [PE_NUM-1:0][SW-1:0]   hold_q;
   logic                        p_out_v_q;
   logic                        partial_q;

   logic [PE_NUM-1:0][SW-1:0]   frame_d;
   logic                        accept;
   logic                        consume;
   logic                        holder_free;
   logic                        full_close;
   logic                        flush_close;
   logic                        close;

   assign s_in_rdy      = (state_q == S_FILL) && rst;
   assign p_out_v       = p_out_v_q;
   assign p_out         = hold_q;
   assign p_out_partial = partial_q;
   assign fill_cnt      = fill_cnt_q;

   // frame_d is the bank as it would look after this edge's accept, with every
   // lane at or above the write position forced to zero.
   always_comb begin
      accept      = s_in_v && s_in_rdy;
      consume     = p_out_v_q && p_out_rdy;
      holder_free = !p_out_v_q || p_out_rdy;
      full_close  = accept && (fill_cnt_q == C_LAST_CNT);
      flush_close = flush && ((fill_cnt_q != '0) || accept) && !full_close;
      close       = (state_q == S_FILL) && (full_close || flush_close);
      frame_d     = '0;
      for (int j = 0; j < PE_NUM; j++) begin
         if (CW'(j) < fill_cnt_q)
            frame_d[j] = bank_q[j];
         else if (accept && (CW'(j) == fill_cnt_q))
            frame_d[j] = s_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= S_FILL;
         bank_q         <= '0;
         bank_partial_q <= 1'b0;
         fill_cnt_q     <= '0;
         hold_q         <= '0;
         p_out_v_q      <= 1'b0;
         partial_q      <= 1'b0;
      end else begin
         case (state_q)
            S_FILL: begin
               if (close) begin
                  if (holder_free) begin
                     hold_q     <= frame_d;
                     partial_q  <= flush_close;
                     p_out_v_q  <= 1'b1;
                     fill_cnt_q <= '0;
                  end else begin
                     // Holder busy and not draining: park the frame in the bank.
                     bank_q         <= frame_d;
                     bank_partial_q <= flush_close;
                     fill_cnt_q     <= C_FULL_CNT;
                     state_q        <= S_WAIT;
                  end
               end else begin
                  if (accept) begin
                     bank_q     <= frame_d;
                     fill_cnt_q <= fill_cnt_q + CW'(1);
                  end
                  if (consume)
                     p_out_v_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (consume) begin
                  hold_q     <= bank_q;
                  partial_q  <= bank_partial_q;
                  fill_cnt_q <= '0;
                  state_q    <= S_FILL;
               end
            end
            default: state_q <= S_FILL;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sipo_pack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sipo_pack
//  Brief    : Directed and scoreboarded bench for sipo_pack (PE_NUM=4, 16-bit).
//  Revision : 1.0
// ============================================================================
module tb_sipo_pack;

   localparam int PE = 4;
   localparam int DW = 16;
   localparam int SW = 2 * DW;
   localparam int FW = PE * SW;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            s_in_v = 1'b0;
   logic [SW-1:0]   s_in = '0;
   logic            s_in_rdy;
   logic            flush = 1'b0;
   logic            p_out_v;
   logic [FW-1:0]   p_out;
   logic            p_out_rdy = 1'b0;
   logic            p_out_partial;
   logic [2:0]      fill_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   sipo_pack #(.PE_NUM(PE), .DATA_WIDTH(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_in_v       (s_in_v),
      .s_in         (s_in),
      .s_in_rdy     (s_in_rdy),
      .flush        (flush),
      .p_out_v      (p_out_v),
      .p_out        (p_out),
      .p_out_rdy    (p_out_rdy),
      .p_out_partial(p_out_partial),
      .fill_cnt     (fill_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SW-1:0] smp(input int k);
      return {16'(k), 16'(k)};
   endfunction

   logic [FW-1:0] asm_q;
   int            asm_cnt;
   logic [FW-1:0] exp_q[$];
   logic [FW-1:0] prev_out;
   logic          prev_stall;
   int            accepted;
   int            cycles;

   initial begin
      // Reset
      step(); step();
      chk("rst_fill_cnt", FW'(fill_cnt), '0);
      chk("rst_p_out_v",  FW'(p_out_v), '0);
      chk("rst_p_out",    p_out, '0);
      chk("rst_partial",  FW'(p_out_partial), '0);
      chk("rst_rdy_low",  FW'(s_in_rdy), '0);
      rst = 1'b1;
      #1;
      chk("rdy_after_rst", FW'(s_in_rdy), 1);

      // Full frame, back-to-back
      p_out_rdy = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         s_in_v = 1'b1; s_in = smp(i);
         chk("full_rdy_stream", FW'(s_in_rdy), 1);
         step();
      end
      s_in_v = 1'b0;
      chk("full_v",       FW'(p_out_v), 1);
      chk("full_data",    p_out, 128'h00040004_00030003_00020002_00010001);
      chk("full_partial", FW'(p_out_partial), 0);
      chk("full_cnt",     FW'(fill_cnt), 0);
      step();
      chk("full_consumed", FW'(p_out_v), 0);

      // Backpressure: two frames, second parked in the bank
      p_out_rdy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s_in_v = 1'b1; s_in = smp(16'h10 + i);
         step();
      end
      s_in_v = 1'b0;
      chk("bp_v",    FW'(p_out_v), 1);
      chk("bp_f1",   p_out, 128'h00130013_00120012_00110011_00100010);
      chk("bp_cnt",  FW'(fill_cnt), 4);
      chk("bp_rdy",  FW'(s_in_rdy), 0);
      step();
      chk("bp_stable", p_out, 128'h00130013_00120012_00110011_00100010);
      p_out_rdy = 1'b1;
      step();
      p_out_rdy = 1'b0;
      chk("bp_f2",     p_out, 128'h00170017_00160016_00150015_00140014);
      chk("bp_f2_v",   FW'(p_out_v), 1);
      chk("bp_rdy_up", FW'(s_in_rdy), 1);
      chk("bp_cnt0",   FW'(fill_cnt), 0);
      p_out_rdy = 1'b1;
      step();
      chk("bp_drain", FW'(p_out_v), 0);

      // Flush after two samples, then a flush with nothing filled
      s_in_v = 1'b1; s_in = 32'h0A0A0A0A; step();
      s_in = 32'h0B0B0B0B; step();
      s_in_v = 1'b0; flush = 1'b1; step();
      flush = 1'b0;
      chk("fl_v",       FW'(p_out_v), 1);
      chk("fl_data",    p_out, 128'h00000000_00000000_0B0B0B0B_0A0A0A0A);
      chk("fl_partial", FW'(p_out_partial), 1);
      chk("fl_cnt",     FW'(fill_cnt), 0);
      step();
      chk("fl_consumed", FW'(p_out_v), 0);
      flush = 1'b1; step(); flush = 1'b0;
      chk("fl_empty_v",   FW'(p_out_v), 0);
      chk("fl_empty_cnt", FW'(fill_cnt), 0);

      // Sample with flush on one edge; closing sample on the consume edge
      p_out_rdy = 1'b0;
      s_in_v = 1'b1; s_in = 32'h0A0A0A0A; step();
      s_in = 32'h0B0B0B0B; step();
      s_in = 32'h0C0C0C0C; flush = 1'b1; step();
      flush = 1'b0;
      chk("sim_flush_data",    p_out, 128'h00000000_0C0C0C0C_0B0B0B0B_0A0A0A0A);
      chk("sim_flush_partial", FW'(p_out_partial), 1);
      s_in = 32'h0D0D0D0D; step();
      s_in = 32'h0E0E0E0E; step();
      s_in = 32'h0F0F0F0F; step();
      chk("sim_hold_stable", p_out, 128'h00000000_0C0C0C0C_0B0B0B0B_0A0A0A0A);
      s_in = 32'h10101010; p_out_rdy = 1'b1; step();
      s_in_v = 1'b0;
      chk("sim_nogap_v",       FW'(p_out_v), 1);
      chk("sim_nogap_data",    p_out, 128'h10101010_0F0F0F0F_0E0E0E0E_0D0D0D0D);
      chk("sim_nogap_partial", FW'(p_out_partial), 0);
      step();
      chk("sim_drain", FW'(p_out_v), 0);

      // Reset mid-frame
      for (int i = 0; i < 3; i++) begin
         s_in_v = 1'b1; s_in = smp(16'h50 + i); step();
      end
      s_in_v = 1'b0; rst = 1'b0; step(); rst = 1'b1;
      chk("mr_cnt", FW'(fill_cnt), 0);
      chk("mr_v",   FW'(p_out_v), 0);
      for (int i = 0; i < 4; i++) begin
         s_in_v = 1'b1; s_in = smp(16'h60 + i); step();
      end
      s_in_v = 1'b0;
      chk("mr_frame", p_out, 128'h00630063_00620062_00610061_00600060);
      chk("mr_frame_v", FW'(p_out_v), 1);
      step();

      // Random streaming against a scoreboard
      asm_q = '0; asm_cnt = 0; accepted = 0; cycles = 0; prev_stall = 1'b0;
      while ((accepted < 64 || exp_q.size() != 0 || p_out_v) && cycles < 3000) begin
         s_in_v    = (accepted < 64) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
         s_in      = $urandom;
         p_out_rdy = (accepted < 64) ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (prev_stall) chk("st_stall_stable", p_out, prev_out);
         if (p_out_v && p_out_rdy) begin
            if (exp_q.size() == 0) chk("st_unexpected", p_out, '0);
            else chk("st_frame", p_out, exp_q.pop_front());
         end
         if (s_in_v && s_in_rdy) begin
            asm_q[asm_cnt*SW +: SW] = s_in;
            asm_cnt++;
            accepted++;
            if (asm_cnt == PE) begin
               exp_q.push_back(asm_q);
               asm_q = '0;
               asm_cnt = 0;
            end
         end
         prev_stall = p_out_v && !p_out_rdy;
         prev_out   = p_out;
         step();
         cycles++;
      end
      s_in_v = 1'b0;
      chk("st_budget",   FW'(cycles < 3000), 1);
      chk("st_accepted", FW'(accepted), 64);
      chk("st_drained",  FW'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sipo_pack.md
SIPO_PACK -- requirements
Module: sipo_pack

Interface
REQ-001 SHALL have parameter PE_NUM, default 8: number of PE lanes, also samples per frame; legal range >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: width of one I or Q component, so a sample is 2*DATA_WIDTH bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port s_in_v, input, 1 bit: serial sample valid.
REQ-006 SHALL have port s_in, input, 2*DATA_WIDTH bits: serial complex sample, {Q,I}.
REQ-007 SHALL have port s_in_rdy, output, 1 bit: block can accept a sample this cycle.
REQ-008 SHALL have port flush, input, 1 bit: close the current partial frame.
REQ-009 SHALL have port p_out_v, output, 1 bit: parallel frame valid.
REQ-010 SHALL have port p_out, output, PE_NUM*2*DATA_WIDTH bits: lane j occupies bits [(j+1)*2*DATA_WIDTH-1 : j*2*DATA_WIDTH].
REQ-011 SHALL have port p_out_rdy, input, 1 bit: downstream (PE array load) accepts the frame.
REQ-012 SHALL have port p_out_partial, output, 1 bit: the held frame was closed by flush.
REQ-013 SHALL have port fill_cnt, output, clog2(PE_NUM+1) bits: samples in the filling bank.

Function
REQ-014 SHALL treat a sample as accepted on an edge where s_in_v && s_in_rdy; a frame as consumed on an edge where p_out_v && p_out_rdy.
REQ-015 SHALL write the k-th accepted sample of a frame (k = 0..PE_NUM-1) into lane k of the filling bank; lane 0 is the first sample received.
REQ-016 SHALL use two storage stages: a filling bank plus fill_cnt, and a holding register that drives p_out.
REQ-017 SHALL implement states FILL and WAIT; s_in_rdy = 1 only in FILL and only while rst is high.
REQ-018 SHALL close a frame in FILL when an accept brings fill_cnt to PE_NUM.
REQ-019 SHALL close a frame in FILL on flush when fill_cnt > 0, or when an accept occurs on the same edge.
REQ-020 On a flush-closed frame, SHALL include any same-edge accepted sample, zero all unwritten lanes, and set p_out_partial.
REQ-021 SHALL ignore flush when fill_cnt = 0 and no accept occurs, and SHALL ignore flush in WAIT.
REQ-022 On close, if the holding register is empty or consumed on the same edge, SHALL transfer the frame to the holding register on that edge, set p_out_v = 1, clear fill_cnt to 0, and remain in FILL.
REQ-023 On close otherwise, SHALL go to WAIT, keep the frame in the bank, and hold fill_cnt = PE_NUM.
REQ-024 In WAIT, on the edge the held frame is consumed, SHALL transfer the bank, keep p_out_v = 1, clear fill_cnt, and return to FILL.
REQ-025 SHALL clear p_out_v on consumption unless a transfer occurs on the same edge.
REQ-026 SHALL keep p_out and p_out_partial stable while p_out_v && !p_out_rdy.
REQ-027 SHALL have latency of 1 edge: frame-closing accept at edge N gives p_out_v high in the cycle after N when the holder is free.
REQ-028 SHALL sustain a throughput of one sample per clock with p_out_rdy held high, with no bubbles on s_in_rdy.
REQ-029 SHALL ignore s_in when s_in_rdy = 0; an s_in_v presented while not ready is not lost, only held off upstream.

Reset
REQ-030 While rst = 0 at an edge, SHALL set state FILL, fill_cnt 0, p_out_v 0, p_out 0, p_out_partial 0, and clear the bank to 0.
REQ-031 SHALL discard any partial or held frame on reset mid-operation, with no output produced for it.
REQ-032 SHALL drive s_in_rdy = 1 in the first cycle after rst returns high.

Verification (PE_NUM=4, DATA_WIDTH=16)
REQ-033 Full frame: send samples 0x00010001..0x00040004 back-to-back, p_out_rdy=1 -> next cycle p_out_v=1, p_out=0x00040004_00030003_00020002_00010001, p_out_partial=0.
REQ-034 Backpressure: p_out_rdy=0, stream 8 samples -> frame 1 held, second bank fills, fill_cnt=4, s_in_rdy=0; raise p_out_rdy one cycle -> frame 2 is presented next and s_in_rdy=1.
REQ-035 Flush: 2 samples (A,B) then flush -> p_out={0,0,B,A}, p_out_partial=1; flush with fill_cnt=0 -> no output.
REQ-036 Simultaneous events: 3rd sample C accepted with flush on the same edge -> p_out={0,C,B,A}; 4th sample accepted on the same edge as consumption -> p_out_v stays 1 and the new frame appears with no gap.
REQ-037 Reset mid-frame: 3 samples then rst=0 for 1 cycle -> fill_cnt=0, p_out_v=0; then 4 samples -> clean frame containing only the post-reset data.
REQ-038 Streaming: 64 random samples, p_out_rdy random -> every frame matches the scoreboard in order, no sample is lost or duplicated, and p_out is stable under stall.
